// File: rtl/vga_rect_pkg.sv
// Shared constants, register map and FSM state type for the rectangle controller.
package vga_rect_pkg;

    localparam int unsigned H_ACTIVE_DEFAULT = 640;
    localparam int unsigned V_ACTIVE_DEFAULT = 480;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_XPOS   = 3'd1;
    localparam logic [2:0] ADDR_YPOS   = 3'd2;
    localparam logic [2:0] ADDR_SIZE   = 3'd3;
    localparam logic [2:0] ADDR_VEL    = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    localparam int unsigned CTRL_AUTO = 0;
    localparam int unsigned CTRL_SHOW = 1;

    typedef enum logic [2:0] {
        StIdle,
        StCommit,
        StStepX,
        StStepY,
        StDone
    } state_e;

endpackage

// File: rtl/rect_axis_step.sv
// One-axis bounce step: advance pos by delta in the current direction, reflecting at 0 and max.
module rect_axis_step #(
    parameter int unsigned COORD_W = 11
) (
    input  logic [COORD_W-1:0] pos_i,
    input  logic [3:0]         delta_i,
    input  logic               dir_i,
    input  logic [COORD_W-1:0] max_i,
    output logic [COORD_W-1:0] pos_o,
    output logic               dir_o
);

    logic [COORD_W-1:0] delta_ext;
    logic [COORD_W-1:0] sum;

    assign delta_ext = COORD_W'(delta_i);
    assign sum       = pos_i + delta_ext;

    always_comb begin
        pos_o = pos_i;
        dir_o = dir_i;
        // A zero delta freezes the axis, including its direction.
        if (delta_i != 4'd0) begin
            if (!dir_i) begin
                if (sum >= max_i) begin
                    pos_o = max_i;
                    dir_o = 1'b1;
                end else begin
                    pos_o = sum;
                end
            end else begin
                if (pos_i <= delta_ext) begin
                    pos_o = '0;
                    dir_o = 1'b0;
                end else begin
                    pos_o = pos_i - delta_ext;
                end
            end
        end
    end

endmodule

// File: rtl/vga_rect_ctrl.sv
// Rectangle bounds controller: CPU shadow registers committed to live bounds once per frame,
// with optional per-frame bounce animation.
module vga_rect_ctrl import vga_rect_pkg::*; #(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEFAULT,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEFAULT,
    parameter int unsigned COORD_W  = 11
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    input  logic               VGA_VS,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [2:0]         addr,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    output logic [COORD_W-1:0] x1,
    output logic [COORD_W-1:0] x2,
    output logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] y2,
    output logic               frame_irq
);

    state_e             state_q, state_d;
    logic               vs_q, vs_d, vs_prev_q, vs_prev_d;
    logic [1:0]         sh_ctrl_q, sh_ctrl_d;
    logic [COORD_W-1:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d;
    logic [7:0]         sh_w_q, sh_w_d, sh_h_q, sh_h_d;
    logic [3:0]         sh_dx_q, sh_dx_d, sh_dy_q, sh_dy_d;
    logic               dirty_x_q, dirty_x_d, dirty_y_q, dirty_y_d;
    logic               lv_show_q, lv_show_d;
    logic [COORD_W-1:0] lv_x_q, lv_x_d, lv_y_q, lv_y_d;
    logic [7:0]         lv_w_q, lv_w_d, lv_h_q, lv_h_d;
    logic [3:0]         lv_dx_q, lv_dx_d, lv_dy_q, lv_dy_d;
    logic               dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic [31:0]        rd_data_q, rd_data_d;
    logic               frame_irq_q, frame_irq_d;
    logic [COORD_W-1:0] x1_q, x1_d, x2_q, x2_d, y1_q, y1_d, y2_q, y2_d;

    logic               frame_event;
    logic [COORD_W-1:0] h_lim, v_lim;
    logic [COORD_W-1:0] xmax_sh, ymax_sh, xmax_lv, ymax_lv;
    logic [COORD_W-1:0] commit_x, commit_y;
    logic [COORD_W-1:0] step_x_pos, step_y_pos;
    logic               step_x_dir, step_y_dir;
    logic               unused_wr_hi;

    assign unused_wr_hi = ^wr_data[31:16];
    assign frame_event  = vs_prev_q & ~vs_q;

    assign h_lim    = COORD_W'(H_ACTIVE - 1);
    assign v_lim    = COORD_W'(V_ACTIVE - 1);
    // Commit clamps against the incoming size; stepping uses the live size.
    assign xmax_sh  = h_lim - COORD_W'(sh_w_q);
    assign ymax_sh  = v_lim - COORD_W'(sh_h_q);
    assign xmax_lv  = h_lim - COORD_W'(lv_w_q);
    assign ymax_lv  = v_lim - COORD_W'(lv_h_q);
    assign commit_x = dirty_x_q ? sh_x_q : lv_x_q;
    assign commit_y = dirty_y_q ? sh_y_q : lv_y_q;

    rect_axis_step #(
        .COORD_W(COORD_W)
    ) u_step_x (
        .pos_i  (lv_x_q),
        .delta_i(lv_dx_q),
        .dir_i  (dir_x_q),
        .max_i  (xmax_lv),
        .pos_o  (step_x_pos),
        .dir_o  (step_x_dir)
    );

    rect_axis_step #(
        .COORD_W(COORD_W)
    ) u_step_y (
        .pos_i  (lv_y_q),
        .delta_i(lv_dy_q),
        .dir_i  (dir_y_q),
        .max_i  (ymax_lv),
        .pos_o  (step_y_pos),
        .dir_o  (step_y_dir)
    );

    always_comb begin
        vs_d        = VGA_VS;
        vs_prev_d   = vs_q;
        state_d     = state_q;
        sh_ctrl_d   = sh_ctrl_q;
        sh_x_d      = sh_x_q;
        sh_y_d      = sh_y_q;
        sh_w_d      = sh_w_q;
        sh_h_d      = sh_h_q;
        sh_dx_d     = sh_dx_q;
        sh_dy_d     = sh_dy_q;
        dirty_x_d   = dirty_x_q;
        dirty_y_d   = dirty_y_q;
        lv_show_d   = lv_show_q;
        lv_x_d      = lv_x_q;
        lv_y_d      = lv_y_q;
        lv_w_d      = lv_w_q;
        lv_h_d      = lv_h_q;
        lv_dx_d     = lv_dx_q;
        lv_dy_d     = lv_dy_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        frame_cnt_d = frame_cnt_q;
        rd_data_d   = rd_data_q;
        frame_irq_d = 1'b0;
        x1_d        = x1_q;
        x2_d        = x2_q;
        y1_d        = y1_q;
        y2_d        = y2_q;

        unique case (state_q)
            StIdle: begin
                if (frame_event) state_d = StCommit;
            end
            StCommit: begin
                lv_show_d = sh_ctrl_q[CTRL_SHOW];
                lv_w_d    = sh_w_q;
                lv_h_d    = sh_h_q;
                lv_dx_d   = sh_dx_q;
                lv_dy_d   = sh_dy_q;
                lv_x_d    = (commit_x > xmax_sh) ? xmax_sh : commit_x;
                lv_y_d    = (commit_y > ymax_sh) ? ymax_sh : commit_y;
                dirty_x_d = 1'b0;
                dirty_y_d = 1'b0;
                state_d   = sh_ctrl_q[CTRL_AUTO] ? StStepX : StDone;
            end
            StStepX: begin
                lv_x_d  = step_x_pos;
                dir_x_d = step_x_dir;
                state_d = StStepY;
            end
            StStepY: begin
                lv_y_d  = step_y_pos;
                dir_y_d = step_y_dir;
                state_d = StDone;
            end
            StDone: begin
                if (lv_show_q) begin
                    x1_d = lv_x_q;
                    x2_d = lv_x_q + COORD_W'(lv_w_q) + COORD_W'(1);
                    y1_d = lv_y_q;
                    y2_d = lv_y_q + COORD_W'(lv_h_q) + COORD_W'(1);
                end else begin
                    x1_d = '0;
                    x2_d = '0;
                    y1_d = '0;
                    y2_d = '0;
                end
                frame_cnt_d = frame_cnt_q + 16'd1;
                frame_irq_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Bus writes come after the FSM so a write during commit re-arms its dirty flag.
        if (wr_en) begin
            case (addr)
                ADDR_CTRL: sh_ctrl_d = wr_data[1:0];
                ADDR_XPOS: begin
                    sh_x_d    = wr_data[COORD_W-1:0];
                    dirty_x_d = 1'b1;
                end
                ADDR_YPOS: begin
                    sh_y_d    = wr_data[COORD_W-1:0];
                    dirty_y_d = 1'b1;
                end
                ADDR_SIZE: begin
                    sh_w_d = (wr_data[7:0] == 8'd0) ? 8'd1 : wr_data[7:0];
                    sh_h_d = (wr_data[15:8] == 8'd0) ? 8'd1 : wr_data[15:8];
                end
                ADDR_VEL: begin
                    sh_dx_d = wr_data[3:0];
                    sh_dy_d = wr_data[7:4];
                end
                default: ;
            endcase
        end

        if (rd_en) begin
            case (addr)
                ADDR_CTRL:   rd_data_d = {30'd0, sh_ctrl_q};
                ADDR_XPOS:   rd_data_d = 32'(lv_x_q);
                ADDR_YPOS:   rd_data_d = 32'(lv_y_q);
                ADDR_SIZE:   rd_data_d = {16'd0, sh_h_q, sh_w_q};
                ADDR_VEL:    rd_data_d = {24'd0, sh_dy_q, sh_dx_q};
                ADDR_STATUS: rd_data_d = {14'd0, dir_y_q, dir_x_q, frame_cnt_q};
                default:     rd_data_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q     <= StIdle;
            vs_q        <= 1'b0;
            vs_prev_q   <= 1'b0;
            sh_ctrl_q   <= '0;
            sh_x_q      <= '0;
            sh_y_q      <= '0;
            sh_w_q      <= 8'd1;
            sh_h_q      <= 8'd1;
            sh_dx_q     <= '0;
            sh_dy_q     <= '0;
            dirty_x_q   <= 1'b0;
            dirty_y_q   <= 1'b0;
            lv_show_q   <= 1'b0;
            lv_x_q      <= '0;
            lv_y_q      <= '0;
            lv_w_q      <= 8'd1;
            lv_h_q      <= 8'd1;
            lv_dx_q     <= '0;
            lv_dy_q     <= '0;
            dir_x_q     <= 1'b0;
            dir_y_q     <= 1'b0;
            frame_cnt_q <= '0;
            rd_data_q   <= '0;
            frame_irq_q <= 1'b0;
            x1_q        <= '0;
            x2_q        <= '0;
            y1_q        <= '0;
            y2_q        <= '0;
        end else begin
            state_q     <= state_d;
            vs_q        <= vs_d;
            vs_prev_q   <= vs_prev_d;
            sh_ctrl_q   <= sh_ctrl_d;
            sh_x_q      <= sh_x_d;
            sh_y_q      <= sh_y_d;
            sh_w_q      <= sh_w_d;
            sh_h_q      <= sh_h_d;
            sh_dx_q     <= sh_dx_d;
            sh_dy_q     <= sh_dy_d;
            dirty_x_q   <= dirty_x_d;
            dirty_y_q   <= dirty_y_d;
            lv_show_q   <= lv_show_d;
            lv_x_q      <= lv_x_d;
            lv_y_q      <= lv_y_d;
            lv_w_q      <= lv_w_d;
            lv_h_q      <= lv_h_d;
            lv_dx_q     <= lv_dx_d;
            lv_dy_q     <= lv_dy_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            frame_cnt_q <= frame_cnt_d;
            rd_data_q   <= rd_data_d;
            frame_irq_q <= frame_irq_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign frame_irq = frame_irq_q;
    assign x1        = x1_q;
    assign x2        = x2_q;
    assign y1        = y1_q;
    assign y2        = y2_q;

endmodule

// File: tb/tb_vga_rect_ctrl.sv
// Directed bench for vga_rect_ctrl: register access, commit, clamping, bounce and reset.
module tb_vga_rect_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vga_vs = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] rd_data;
    logic [10:0] x1, x2, y1, y2;
    logic        frame_irq;

    int n_checks = 0;
    int n_fail   = 0;

    vga_rect_ctrl u_dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .VGA_VS   (vga_vs),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .x1       (x1),
        .x2       (x2),
        .y1       (y1),
        .y2       (y2),
        .frame_irq(frame_irq)
    );

    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        addr    = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        rd_en = 1'b1;
        addr  = a;
        tick();
        rd_en = 1'b0;
        d     = rd_data;
    endtask

    // Drop VSYNC, count edges until frame_irq, then confirm the pulse is one cycle wide.
    task automatic do_frame(input string tag, input int exp_lat);
        int n;
        n      = 0;
        vga_vs = 1'b0;
        do begin
            tick();
            n++;
        end while (!frame_irq && n < 20);
        check_eq({tag, "_latency"}, n, exp_lat);
        vga_vs = 1'b1;
        tick();
        check_eq({tag, "_irq_pulse"}, {31'd0, frame_irq}, 32'd0);
        tick();
    endtask

    task automatic check_bounds(input string tag, input int ex1, input int ex2, input int ey1,
                                input int ey2);
        check_eq({tag, "_x1"}, 32'(x1), ex1);
        check_eq({tag, "_x2"}, 32'(x2), ex2);
        check_eq({tag, "_y1"}, 32'(y1), ey1);
        check_eq({tag, "_y2"}, 32'(y2), ey2);
    endtask

    initial begin
        logic [31:0] rv;

        repeat (3) tick();
        check_bounds("rst", 0, 0, 0, 0);
        check_eq("rst_irq", {31'd0, frame_irq}, 32'd0);
        check_eq("rst_rd_data", rd_data, 32'd0);
        rst = 1'b0;
        repeat (2) tick();
        bus_read(3'd5, rv);
        check_eq("rst_status", rv, 32'd0);
        bus_read(3'd3, rv);
        check_eq("rst_size", rv, 32'h0101);

        // Nothing written: SHOW=0 keeps the rectangle hidden.
        do_frame("f1", 4);
        check_bounds("f1", 0, 0, 0, 0);
        bus_read(3'd5, rv);
        check_eq("f1_status", rv, 32'd1);

        bus_write(3'd0, 32'd2);
        bus_write(3'd1, 32'd100);
        bus_write(3'd2, 32'd50);
        bus_write(3'd3, 32'h1010);
        tick();
        check_bounds("pre_f2", 0, 0, 0, 0);
        bus_read(3'd1, rv);
        check_eq("pre_f2_live_x", rv, 32'd0);
        bus_read(3'd0, rv);
        check_eq("ctrl_rd", rv, 32'd2);
        do_frame("f2", 4);
        check_bounds("f2", 100, 117, 50, 67);
        bus_read(3'd1, rv);
        check_eq("f2_live_x", rv, 32'd100);

        // Out-of-range X clamps to 639-16.
        bus_write(3'd1, 32'd700);
        do_frame("f3", 4);
        check_bounds("f3", 623, 640, 50, 67);
        bus_read(3'd1, rv);
        check_eq("f3_live_x", rv, 32'd623);

        // Auto X bounce at the right edge.
        bus_write(3'd4, 32'h05);
        bus_write(3'd1, 32'd615);
        bus_write(3'd0, 32'd3);
        do_frame("f4", 6);
        check_bounds("f4", 620, 637, 50, 67);
        do_frame("f5", 6);
        check_bounds("f5", 623, 640, 50, 67);
        bus_read(3'd5, rv);
        check_eq("f5_status", rv, 32'h1_0005);
        do_frame("f6", 6);
        check_bounds("f6", 618, 635, 50, 67);
        bus_read(3'd5, rv);
        check_eq("f6_status", rv, 32'h1_0006);

        // Y bounce at the bottom, then at the top; DX=0 freezes x.
        bus_write(3'd4, 32'h40);
        bus_write(3'd2, 32'd460);
        do_frame("f7", 6);
        check_bounds("f7", 618, 635, 463, 480);
        bus_read(3'd5, rv);
        check_eq("f7_status", rv, 32'h3_0007);
        bus_write(3'd2, 32'd2);
        do_frame("f8", 6);
        check_bounds("f8", 618, 635, 0, 17);
        bus_read(3'd5, rv);
        check_eq("f8_status", rv, 32'h1_0008);
        do_frame("f9", 6);
        check_bounds("f9", 618, 635, 4, 21);

        bus_write(3'd6, 32'hFFFF);
        bus_read(3'd6, rv);
        check_eq("addr6_rd", rv, 32'd0);
        bus_write(3'd3, 32'd0);
        bus_read(3'd3, rv);
        check_eq("size_zero_to_one", rv, 32'h0101);

        // Reset while the FSM sits in STEP_X.
        vga_vs = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_bounds("midrst", 0, 0, 0, 0);
        check_eq("midrst_irq", {31'd0, frame_irq}, 32'd0);
        rst    = 1'b0;
        vga_vs = 1'b1;
        repeat (2) tick();
        bus_read(3'd0, rv);
        check_eq("midrst_ctrl", rv, 32'd0);
        bus_read(3'd1, rv);
        check_eq("midrst_live_x", rv, 32'd0);
        do_frame("f10", 4);
        check_bounds("f10", 0, 0, 0, 0);
        bus_read(3'd5, rv);
        check_eq("f10_status", rv, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
